tinycore_boot_mem: RTL and testbench

Program memory and boot loader for the tinycore CPU. It holds a 2^ADDR_SZ x DATA_SZ RAM and keeps the core in reset while it loads a program from a byte stream over a valid/ready handshake. It then releases the core and serves its memory bus. It also provides one memory-mapped output register at the all-ones address. It sits directly on the core's `addr` / `data_o` / `we` / `data_i` bus.

---
 rtl/tinycore_boot_mem.sv | 139 +++++++++++++
 tb/tb_tinycore_boot_mem.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/tinycore_boot_mem.sv
// Program RAM and stream boot loader for the tinycore CPU.
// Holds the core in reset while a length-prefixed program is streamed in, then serves the core bus.
module tinycore_boot_mem #(
  parameter int ADDR_SZ = 8,
  parameter int DATA_SZ = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld_valid,
  input  logic [DATA_SZ-1:0] ld_data,
  output logic               ld_ready,
  input  logic               reload,
  input  logic [ADDR_SZ-1:0] cpu_addr,
  input  logic [DATA_SZ-1:0] cpu_wdata,
  input  logic               cpu_we,
  output logic [DATA_SZ-1:0] cpu_rdata,
  output logic               core_rst_n,
  output logic               busy,
  output logic [DATA_SZ-1:0] io_out
);

  localparam int unsigned DEPTH = 1 << ADDR_SZ;
  localparam logic [ADDR_SZ-1:0] ADDR_ONES = '1;
  localparam logic [ADDR_SZ-1:0] ADDR_ONE  = ADDR_SZ'(1);

  typedef enum logic [1:0] {
    WAIT_LEN = 2'd0,
    LOAD     = 2'd1,
    RUN      = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_SZ-1:0] mem [DEPTH];

  logic [ADDR_SZ-1:0] len, len_nxt;
  logic [ADDR_SZ-1:0] wp, wp_nxt;
  logic [ADDR_SZ:0]   len_ext;
  logic [ADDR_SZ-1:0] len_clamped;

  logic               ld_fire;
  logic               io_hit;
  logic               ram_we;
  logic [ADDR_SZ-1:0] ram_waddr;
  logic [DATA_SZ-1:0] ram_wdata;
  logic               io_we;

  // Length word resized to ADDR_SZ+1 bits before the clamp.
  if (DATA_SZ >= ADDR_SZ + 1) begin : g_len_trunc
    assign len_ext = ld_data[ADDR_SZ:0];
  end else begin : g_len_zext
    assign len_ext = {{(ADDR_SZ + 1 - DATA_SZ){1'b0}}, ld_data};
  end

  // Clamp to 2^ADDR_SZ-1 so the io register address is never loaded.
  assign len_clamped = len_ext[ADDR_SZ] ? ADDR_ONES : len_ext[ADDR_SZ-1:0];

  assign busy     = (state != RUN);
  assign ld_ready = busy;
  assign ld_fire  = ld_valid & ld_ready;
  assign io_hit   = (cpu_addr == ADDR_ONES);

  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    wp_nxt    = wp;
    unique case (state)
      WAIT_LEN: begin
        if (ld_fire) begin
          len_nxt   = len_clamped;
          wp_nxt    = '0;
          state_nxt = (len_clamped == '0) ? RUN : LOAD;
        end
      end
      LOAD: begin
        if (ld_fire) begin
          wp_nxt = wp + ADDR_ONE;
          if (wp == len - ADDR_ONE) begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (reload) begin
          state_nxt = WAIT_LEN;
        end
      end
      default: begin
        state_nxt = WAIT_LEN;
      end
    endcase
  end

  // Single RAM write port shared by the loader (LOAD) and the core (RUN).
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wp;
    ram_wdata = ld_data;
    io_we     = 1'b0;
    if (state == LOAD) begin
      ram_we = ld_fire;
    end else if (state == RUN && cpu_we) begin
      if (io_hit) begin
        io_we = 1'b1;
      end else begin
        ram_we    = 1'b1;
        ram_waddr = cpu_addr;
        ram_wdata = cpu_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_LEN;
      len        <= '0;
      wp         <= '0;
      core_rst_n <= 1'b0;
      io_out     <= '0;
    end else begin
      state      <= state_nxt;
      len        <= len_nxt;
      wp         <= wp_nxt;
      core_rst_n <= (state_nxt == RUN);
      if (io_we) begin
        io_out <= cpu_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
  end

  assign cpu_rdata = io_hit ? io_out : mem[cpu_addr];

endmodule

// File: tb/tb_tinycore_boot_mem.sv
// Randomized and directed bench for tinycore_boot_mem against a behavioural loader/memory model.
module tb_tinycore_boot_mem;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = '0;
  logic       ld_ready;
  logic       reload = 1'b0;
  logic [7:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic       cpu_we = 1'b0;
  logic [7:0] cpu_rdata;
  logic       core_rst_n;
  logic       busy;
  logic [7:0] io_out;

  int n_checks = 0;
  int n_fail   = 0;

  tinycore_boot_mem #(.ADDR_SZ(8), .DATA_SZ(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .reload     (reload),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .cpu_rdata  (cpu_rdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .io_out     (io_out)
  );

  always #5 clk = ~clk;

  // Behavioural model: "running" flag, words still expected, next load index.
  bit         m_run     = 1'b0;
  bit         m_waitlen = 1'b1;
  int         m_left    = 0;
  int         m_idx     = 0;
  logic [7:0] m_io      = '0;
  logic [7:0] m_mem   [256];
  bit         m_known [256];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run     = 1'b0;
      m_waitlen = 1'b1;
      m_left    = 0;
      m_idx     = 0;
      m_io      = '0;
    end else if (m_run) begin
      if (cpu_we) begin
        if (cpu_addr == 8'hFF) m_io = cpu_wdata;
        else begin
          m_mem[cpu_addr]   = cpu_wdata;
          m_known[cpu_addr] = 1'b1;
        end
      end
      if (reload) begin
        m_run     = 1'b0;
        m_waitlen = 1'b1;
      end
    end else if (ld_valid) begin
      if (m_waitlen) begin
        m_left = (int'(ld_data) > 255) ? 255 : int'(ld_data);
        m_idx  = 0;
        if (m_left == 0) m_run = 1'b1;
        else m_waitlen = 1'b0;
      end else begin
        m_mem[m_idx]   = ld_data;
        m_known[m_idx] = 1'b1;
        m_idx++;
        m_left--;
        if (m_left == 0) m_run = 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ld_ready", 32'(ld_ready), 32'(!m_run));
    chk("busy", 32'(busy), 32'(!m_run));
    chk("core_rst_n", 32'(core_rst_n), 32'(m_run));
    chk("io_out", 32'(io_out), 32'(m_io));
    if (cpu_addr == 8'hFF) chk("rdata_io", 32'(cpu_rdata), 32'(m_io));
    else if (m_known[cpu_addr]) chk("rdata_mem", 32'(cpu_rdata), 32'(m_mem[cpu_addr]));
  end

  // Holds the given inputs across one rising edge, returns 1 time unit after it.
  task automatic step(input logic v, input logic [7:0] d, input logic we,
                      input logic [7:0] a, input logic [7:0] wd, input logic rl);
    ld_valid  = v;
    ld_data   = d;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    reload    = rl;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
    ld_valid = 1'b0;
    cpu_we   = 1'b0;
    reload   = 1'b0;
    cpu_addr = a;
    #1;
    chk(nm, 32'(cpu_rdata), 32'(exp));
  endtask

  int cnt;
  logic v;

  initial begin
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_core_rst_n", 32'(core_rst_n), 32'h0);
    chk("reset_busy", 32'(busy), 32'h1);
    chk("reset_ld_ready", 32'(ld_ready), 32'h1);
    chk("reset_io_out", 32'(io_out), 32'h0);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0);

    // Length 3 program on consecutive cycles.
    step(1, 8'd3, 0, 0, 0, 0);
    step(1, 8'hA1, 0, 0, 0, 0);
    step(1, 8'hB2, 0, 0, 0, 0);
    chk("load3_core_low", 32'(core_rst_n), 32'h0);
    chk("load3_busy_high", 32'(busy), 32'h1);
    step(1, 8'hC3, 0, 0, 0, 0);
    chk("load3_core_high", 32'(core_rst_n), 32'h1);
    chk("load3_busy_low", 32'(busy), 32'h0);
    chk("load3_ready_low", 32'(ld_ready), 32'h0);
    rd(8'h00, 8'hA1, "load3_ram0");
    rd(8'h01, 8'hB2, "load3_ram1");
    rd(8'h02, 8'hC3, "load3_ram2");

    // Core writes: RAM and the io register.
    step(0, 0, 1, 8'h10, 8'h5A, 0);
    rd(8'h10, 8'h5A, "run_raw_10");
    step(0, 0, 1, 8'hFF, 8'h3C, 0);
    chk("run_io_out", 32'(io_out), 32'h3C);
    rd(8'hFF, 8'h3C, "run_read_ff");

    // Reload and a one-word program; io_out survives.
    step(0, 0, 0, 0, 0, 1);
    chk("reload_core_low", 32'(core_rst_n), 32'h0);
    chk("reload_ready", 32'(ld_ready), 32'h1);
    step(1, 8'd1, 0, 0, 0, 0);
    step(1, 8'h77, 0, 0, 0, 0);
    chk("reload_core_high", 32'(core_rst_n), 32'h1);
    rd(8'h00, 8'h77, "reload_ram0");
    chk("reload_io_kept", 32'(io_out), 32'h3C);

    // Zero length goes straight to RUN.
    step(0, 0, 0, 0, 0, 1);
    step(1, 8'd0, 0, 0, 0, 0);
    chk("len0_core_high", 32'(core_rst_n), 32'h1);
    chk("len0_ready_low", 32'(ld_ready), 32'h0);

    // Core writes during LOAD are ignored.
    step(0, 0, 0, 0, 0, 1);
    step(1, 8'd2, 1, 8'h00, 8'hEE, 0);
    step(1, 8'h11, 1, 8'h00, 8'hEE, 0);
    step(0, 8'h00, 1, 8'h00, 8'hDD, 0);
    step(1, 8'h22, 1, 8'h00, 8'hCC, 0);
    chk("ldwe_core_high", 32'(core_rst_n), 32'h1);
    rd(8'h00, 8'h11, "ldwe_ram0");
    rd(8'h01, 8'h22, "ldwe_ram1");

    // Maximum length with random gaps in ld_valid.
    step(0, 0, 0, 0, 0, 1);
    step(1, 8'hFF, 0, 0, 0, 0);
    cnt = 0;
    for (int c = 0; c < 2000 && cnt < 255; c++) begin
      v = ($urandom_range(0, 2) != 0);
      step(v, 8'(cnt * 7 + 3), 1'(($urandom_range(0, 3)) == 0), 8'($urandom), 8'($urandom), 0);
      if (v) cnt++;
      chk("max_busy", 32'(busy), 32'(cnt < 255));
    end
    chk("max_count", 32'(cnt), 32'd255);
    rd(8'hFE, 8'(254 * 7 + 3), "max_ram_fe");
    rd(8'h80, 8'(128 * 7 + 3), "max_ram_80");
    rd(8'h00, 8'h03, "max_ram_00");

    // rst_n mid-load: outputs return immediately, partial program stays.
    step(0, 0, 1, 8'hFF, 8'h42, 1);
    step(1, 8'd10, 0, 0, 0, 0);
    step(1, 8'h99, 0, 0, 0, 0);
    step(1, 8'h98, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_core", 32'(core_rst_n), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h1);
    chk("midrst_ready", 32'(ld_ready), 32'h1);
    chk("midrst_io", 32'(io_out), 32'h0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    rd(8'h00, 8'h99, "midrst_ram0_kept");
    rd(8'h01, 8'h98, "midrst_ram1_kept");
    step(0, 0, 0, 0, 0, 0);

    // Randomized traffic, checked every cycle by the compare process.
    for (int c = 0; c < 3000; c++) begin
      step(1'(($urandom_range(0, 3)) != 0), 8'($urandom),
           1'(($urandom_range(0, 2)) == 0), 8'($urandom), 8'($urandom),
           1'(($urandom_range(0, 39)) == 0));
    end
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
